// File: rtl/reg_file.sv
// reg_pkg: register selectors, write-mask selectors and STATUS layout shared
// between decode and the architectural register file.
package reg_pkg;

    localparam int unsigned XLEN = 32;

    // Write/read selectors; PCLINK aliases PC on reads and links LR on writes.
    typedef enum logic [3:0] {
        R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10,
        SP, LR, PC, PCLINK, STATUS
    } reg_e;

    typedef enum logic [1:0] {
        LS8, LS16, LS27, LS32
    } reg_mask_e;

    typedef enum logic {
        SUPERVISOR = 1'b0,
        USER       = 1'b1
    } mode_e;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } alu_status_t;

    // mode is bit 0, imask is bit 1, ALU flags above.
    typedef struct packed {
        alu_status_t alu_status;
        logic        imask;
        mode_e       mode;
    } status_t;

    // LS27 covers the low 24 bits (0x00ff_ffff): the 27-bit name is historical.
    function automatic logic [XLEN-1:0] get_mask_32(reg_mask_e sel);
        logic [XLEN-1:0] m;
        case (sel)
            LS8:     m = 32'h0000_00ff;
            LS16:    m = 32'h0000_ffff;
            LS27:    m = 32'h00ff_ffff;
            LS32:    m = 32'hffff_ffff;
            default: m = 32'hffff_ffff;
        endcase
        return m;
    endfunction

endpackage

// reg_file: architectural register file (R0-R10, SP, LR, PC, STATUS).
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   rd_sel_a/b, rd_data_a/b     two combinational read ports (pre-edge values)
//   wr_en, wr_sel, wr_mask,     single masked write port
//   wr_data
//   pc_inc                      PC <= PC + 1 unless PC is written this cycle
//   alu_status_we, alu_status_in ALU flag load unless STATUS is written
//   trap                        trap entry: PC <= TRAP_VEC, LR <= PC, supervisor
//   status, pc                  registered architectural state
//   priv_fault                  one-cycle pulse after a user-mode STATUS write
//                               that tried to change imask/mode
module reg_file
    import reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] RESET_SP = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  reg_e        rd_sel_a,
    input  reg_e        rd_sel_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    input  logic        wr_en,
    input  reg_e        wr_sel,
    input  reg_mask_e   wr_mask,
    input  logic [31:0] wr_data,
    input  logic        pc_inc,
    input  logic        alu_status_we,
    input  alu_status_t alu_status_in,
    input  logic        trap,
    output status_t     status,
    output logic [31:0] pc,
    output logic        priv_fault
);

    localparam int unsigned NUM_GPR  = 11;
    localparam int unsigned NUM_SEL  = 16;
    localparam int unsigned STATUS_W = $bits(status_t);

    localparam status_t STATUS_RESET = '{alu_status: '0, imask: 1'b1, mode: SUPERVISOR};

    logic [31:0] gpr     [NUM_GPR];
    logic [31:0] gpr_nxt [NUM_GPR];
    logic [31:0] sp, sp_nxt;
    logic [31:0] lr, lr_nxt;
    logic [31:0] pc_nxt;
    status_t     status_nxt;
    logic        priv_fault_nxt;

    logic [31:0] view [NUM_SEL];
    logic [31:0] wr_m;
    logic [31:0] wr_new;
    status_t     wr_status;
    logic        wr_pc;
    logic        wr_st;

    // Selector-indexed view of all architectural state for reads and RMW.
    always_comb begin
        for (int i = 0; i < int'(NUM_SEL); i++) view[i] = '0;
        for (int i = 0; i < int'(NUM_GPR); i++) view[i] = gpr[i];
        view[SP]     = sp;
        view[LR]     = lr;
        view[PC]     = pc;
        view[PCLINK] = pc;
        view[STATUS] = 32'(status);
    end

    assign rd_data_a = view[rd_sel_a];
    assign rd_data_b = view[rd_sel_b];

    // Masked read-modify-write value for the write destination.
    assign wr_m      = get_mask_32(wr_mask);
    assign wr_new    = (view[wr_sel] & ~wr_m) | (wr_data & wr_m);
    assign wr_status = status_t'(wr_new[STATUS_W-1:0]);
    assign wr_pc     = wr_en && (wr_sel == PC || wr_sel == PCLINK);
    assign wr_st     = wr_en && (wr_sel == STATUS);

    // Next-state: trap > register write > {pc_inc, alu_status_we}.
    always_comb begin
        gpr_nxt        = gpr;
        sp_nxt         = sp;
        lr_nxt         = lr;
        pc_nxt         = pc;
        status_nxt     = status;
        priv_fault_nxt = 1'b0;

        if (trap) begin
            pc_nxt           = TRAP_VEC;
            lr_nxt           = pc;
            status_nxt.mode  = SUPERVISOR;
            status_nxt.imask = 1'b1;
        end else begin
            if (pc_inc && !wr_pc) pc_nxt = pc + 32'd1;
            if (alu_status_we && !wr_st) status_nxt.alu_status = alu_status_in;

            if (wr_en) begin
                case (wr_sel)
                    SP:     sp_nxt = wr_new;
                    LR:     lr_nxt = wr_new;
                    PC:     pc_nxt = wr_new;
                    PCLINK: begin
                        pc_nxt = wr_new;
                        lr_nxt = pc;
                    end
                    STATUS: begin
                        if (status.mode == SUPERVISOR) begin
                            status_nxt = wr_status;
                        end else begin
                            // User mode may only touch the flags; flag the attempt.
                            status_nxt.alu_status = wr_status.alu_status;
                            priv_fault_nxt = (wr_status.imask != status.imask) ||
                                             (wr_status.mode  != status.mode);
                        end
                    end
                    default: gpr_nxt[wr_sel] = wr_new;
                endcase
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_GPR); i++) gpr[i] <= '0;
            sp         <= RESET_SP;
            lr         <= '0;
            pc         <= RESET_PC;
            status     <= STATUS_RESET;
            priv_fault <= 1'b0;
        end else begin
            gpr        <= gpr_nxt;
            sp         <= sp_nxt;
            lr         <= lr_nxt;
            pc         <= pc_nxt;
            status     <= status_nxt;
            priv_fault <= priv_fault_nxt;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the architectural state.
module tb_reg_file;
    import reg_pkg::*;

    localparam logic [31:0] T_RESET_PC = 32'h0000_1000;
    localparam logic [31:0] T_RESET_SP = 32'h0000_8000;
    localparam logic [31:0] T_TRAP_VEC = 32'h0000_0080;

    logic        clk;
    logic        rst_n;
    reg_e        rd_sel_a, rd_sel_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        wr_en;
    reg_e        wr_sel;
    reg_mask_e   wr_mask;
    logic [31:0] wr_data;
    logic        pc_inc;
    logic        alu_status_we;
    alu_status_t alu_status_in;
    logic        trap;
    status_t     status;
    logic [31:0] pc;
    logic        priv_fault;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] m_gpr [11];
    logic [31:0] m_sp, m_lr, m_pc;
    logic [3:0]  m_alu;
    logic        m_imask, m_mode, m_fault;

    reg_file #(
        .RESET_PC(T_RESET_PC),
        .RESET_SP(T_RESET_SP),
        .TRAP_VEC(T_TRAP_VEC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_mask(wr_mask), .wr_data(wr_data),
        .pc_inc(pc_inc), .alu_status_we(alu_status_we), .alu_status_in(alu_status_in),
        .trap(trap), .status(status), .pc(pc), .priv_fault(priv_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {26'd0, m_alu, m_imask, m_mode};
    endfunction

    function automatic logic [31:0] m_read(input int sel);
        if (sel <= 10)  return m_gpr[sel];
        if (sel == 11)  return m_sp;
        if (sel == 12)  return m_lr;
        if (sel == 15)  return m_status();
        return m_pc;    // PC and PCLINK
    endfunction

    function automatic logic [31:0] mask_bits(input int msel);
        case (msel)
            0:       return 32'h0000_00ff;
            1:       return 32'h0000_ffff;
            2:       return 32'h00ff_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

    // Apply one clock edge's worth of architectural rules to the model.
    task automatic model_step();
        int          sel;
        logic [31:0] nv;
        logic        pc_written, st_written;
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) m_gpr[i] = '0;
            m_sp = T_RESET_SP; m_lr = '0; m_pc = T_RESET_PC;
            m_alu = '0; m_imask = 1'b1; m_mode = 1'b0; m_fault = 1'b0;
            return;
        end
        m_fault = 1'b0;
        if (trap) begin
            m_lr = m_pc; m_pc = T_TRAP_VEC; m_mode = 1'b0; m_imask = 1'b1;
            return;
        end
        sel = int'(wr_sel);
        pc_written = wr_en && (sel == 13 || sel == 14);
        st_written = wr_en && (sel == 15);
        if (wr_en) begin
            nv = (m_read(sel) & ~mask_bits(int'(wr_mask))) | (wr_data & mask_bits(int'(wr_mask)));
            if (sel <= 10)      m_gpr[sel] = nv;
            else if (sel == 11) m_sp = nv;
            else if (sel == 12) m_lr = nv;
            else if (sel == 13) m_pc = nv;
            else if (sel == 14) begin m_lr = m_pc; m_pc = nv; end
            else begin
                if (m_mode == 1'b0) begin
                    m_alu = nv[5:2]; m_imask = nv[1]; m_mode = nv[0];
                end else begin
                    m_fault = (nv[1] != m_imask) || (nv[0] != m_mode);
                    m_alu = nv[5:2];
                end
            end
        end
        if (pc_inc && !pc_written) m_pc = m_pc + 32'd1;
        if (alu_status_we && !st_written) m_alu = alu_status_in;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_sel = R0; wr_mask = LS32; wr_data = '0;
        pc_inc = 1'b0; alu_status_we = 1'b0; alu_status_in = '0; trap = 1'b0;
    endtask

    task automatic wr(input reg_e sel, input reg_mask_e m, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_mask = m; wr_data = d;
    endtask

    // One edge: update model, compare visible state and two random reads.
    task automatic tick();
        int sa, sb;
        @(posedge clk);
        model_step();
        #1;
        check("pc", pc, m_pc);
        check("status", 32'(status), m_status());
        check("priv_fault", 32'(priv_fault), 32'(m_fault));
        sa = $urandom_range(0, 15);
        sb = $urandom_range(0, 15);
        rd_sel_a = reg_e'(4'(sa));
        rd_sel_b = reg_e'(4'(sb));
        #1;
        check("rd_a", rd_data_a, m_read(sa));
        check("rd_b", rd_data_b, m_read(sb));
    endtask

    task automatic check_reg(input string tag, input reg_e sel, input logic [31:0] exp);
        rd_sel_a = sel;
        #1;
        check(tag, rd_data_a, exp);
    endtask

    initial begin
        rd_sel_a = R0; rd_sel_b = R0;
        idle();
        for (int i = 0; i < 11; i++) m_gpr[i] = '0;
        m_sp = '0; m_lr = '0; m_pc = '0; m_alu = '0;
        m_imask = 1'b0; m_mode = 1'b0; m_fault = 1'b0;

        // Reset overrides a concurrent PC write
        rst_n = 1'b0;
        wr(PC, LS32, 32'h0000_0abc);
        @(posedge clk); model_step();
        tick();
        rst_n = 1'b1; idle();
        #1;
        check("rst_pc", pc, T_RESET_PC);
        check("rst_status", 32'(status), 32'h0000_0002);
        check("rst_fault", 32'(priv_fault), 32'd0);
        check_reg("rst_sp", SP, T_RESET_SP);

        // Masked writes
        wr(R2, LS32, 32'hdead_beef); tick();
        wr(R2, LS8, 32'h1234_5678);  tick();
        idle(); check_reg("mask_ls8", R2, 32'hdead_be78);
        wr(R2, LS27, 32'h0);         tick();
        idle(); check_reg("mask_ls27", R2, 32'hde00_0000);

        // PCLINK wins over pc_inc and links LR
        wr(PC, LS32, 32'h0000_0100); tick();
        wr(PCLINK, LS32, 32'h0000_2000); pc_inc = 1'b1; tick();
        idle();
        check("pclink_pc", pc, 32'h0000_2000);
        check_reg("pclink_lr", LR, 32'h0000_0100);
        wr(PC, LS32, 32'hffff_ffff); tick();
        idle(); pc_inc = 1'b1; tick();
        idle();
        check("pc_wrap", pc, 32'h0);

        // Enter user mode, then attempt privileged STATUS changes
        wr(STATUS, LS32, 32'h0000_002b); tick();
        wr(STATUS, LS32, 32'h0); tick();
        idle();
        check("user_status", 32'(status), 32'h0000_0003);
        check("user_fault", 32'(priv_fault), 32'd1);
        tick();
        check("user_fault_pulse", 32'(priv_fault), 32'd0);
        wr(STATUS, LS32, 32'h0000_0013); tick();
        idle();
        check("user_nofault", 32'(priv_fault), 32'd0);
        check("user_status2", 32'(status), 32'h0000_0013);

        // Trap suppresses write and ALU flag load
        wr(PC, LS32, 32'h0000_0040); tick();
        wr(R1, LS32, 32'h0000_0055); alu_status_we = 1'b1; alu_status_in = 4'hf; trap = 1'b1;
        tick();
        idle();
        check("trap_pc", pc, T_TRAP_VEC);
        check("trap_status", 32'(status), 32'h0000_0012);
        check_reg("trap_lr", LR, 32'h0000_0040);
        check_reg("trap_r1", R1, 32'h0);

        // STATUS write beats ALU flag load
        wr(STATUS, LS8, 32'h0000_0035); alu_status_we = 1'b1; alu_status_in = 4'hf;
        tick();
        idle();
        check("st_vs_alu", 32'(status), 32'h0000_0035);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            trap          = ($urandom_range(0, 24) == 0);
            wr_en         = ($urandom_range(0, 1) == 1);
            wr_sel        = reg_e'(4'($urandom_range(0, 15)));
            wr_mask       = reg_mask_e'(2'($urandom_range(0, 3)));
            wr_data       = ($urandom_range(0, 7) == 0) ? 32'hffff_ffff : $urandom;
            pc_inc        = ($urandom_range(0, 1) == 1);
            alu_status_we = ($urandom_range(0, 2) == 0);
            alu_status_in = alu_status_t'(4'($urandom_range(0, 15)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
